muldiv_seq_unit: RTL and testbench

- Iterative multiply/divide sequencer for the MIPS EX stage. Executes MULT, MULTU, DIV and DIVU alongside the single-cycle ALU.
- Owns the HI/LO registers, which are written by the MTHI/MTLO path and read by MFHI/MFLO.
- Drives a busy signal that the hazard unit uses to stall HI/LO readers and back-to-back mul/div issues.

---
 rtl/muldiv_seq_unit.sv | 122 ++++++++++++
 tb/tb_muldiv_seq_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_unit.sv
// muldiv_seq_unit: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO for the MIPS EX stage.
// Define MULDIV_EARLY_OUT_EN to let multiplies leave CALC once the remaining multiplier bits are zero.
module muldiv_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             abort,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, mc;
    logic [WIDTH-1:0]   mq;
    logic               is_div, neg_res, neg_rem, dz;
    logic               accept, early, last, ge;
    logic [WIDTH:0]     trial, diff;
    logic [WIDTH-1:0]   rs_abs, rt_abs, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;

    assign rs_abs = (!op[0] && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign rt_abs = (!op[0] && rt_val[WIDTH-1]) ? -rt_val : rt_val;
    assign accept = (state == IDLE) && start && !abort;
    assign last   = cnt == CW'(WIDTH - 1);
`ifdef MULDIV_EARLY_OUT_EN
    assign early  = !is_div && (mq == '0);
`else
    assign early  = 1'b0;
`endif
    // Restoring divide step: acc holds {remainder, dividend/quotient}, mc[WIDTH-1:0] the divisor.
    assign trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign diff     = trial - {1'b0, mc[WIDTH-1:0]};
    assign ge       = !diff[WIDTH];
    assign prod_fix = neg_res ? -acc : acc;
    assign quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? CALC : IDLE;
            CALC:    state_nx = abort ? IDLE : (last || early) ? FIX : CALC;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = state != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            mc       <= '0;
            mq       <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dz       <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            if (accept) begin
                is_div  <= op[1];
                neg_res <= !op[0] && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                neg_rem <= !op[0] && op[1] && rs_val[WIDTH-1];
                dz      <= op[1] && (rt_val == '0);
                cnt     <= '0;
                acc     <= op[1] ? {{WIDTH{1'b0}}, rs_abs} : '0;
                mc      <= {{WIDTH{1'b0}}, op[1] ? rt_abs : rs_abs};
                mq      <= rt_abs;
            end else if (state == IDLE) begin
                if (mthi_we) hi <= wdata;
                if (mtlo_we) lo <= wdata;
            end else if (state == CALC && !abort) begin
                cnt <= cnt + CW'(1);
                if (is_div) begin
                    acc <= {ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0], acc[WIDTH-2:0], ge};
                end else begin
                    acc <= mq[0] ? acc + mc : acc;
                    mc  <= mc << 1;
                    mq  <= mq >> 1;
                end
            end else if (state == FIX && !abort) begin
                done     <= 1'b1;
                div_zero <= dz;
                if (is_div) begin
                    hi <= rem_fix;
                    lo <= dz ? '1 : quo_fix;
                end else begin
                    {hi, lo} <= prod_fix;
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq_unit.sv
// tb_muldiv_seq_unit: directed scoreboard bench for muldiv_seq_unit (default build, WIDTH=32).
module tb_muldiv_seq_unit;
    logic        clk = 1'b0;
    logic        rst_n, start, abort, mthi_we, mtlo_we;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val, wdata, hi, lo;
    logic        busy, done, div_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    muldiv_seq_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .abort(abort), .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input logic ed);
        exp_t        e;
        logic [31:0] hi_before;
        int          busy_cnt = 0;
        bit          seen = 0;
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        hi_before = hi;
        e.hi = eh; e.lo = el; e.dz = ed;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
        chk({tag, "_hi_hold"}, 64'(hi), 64'(hi_before));
        for (int i = 0; i < 100 && !seen; i++) begin
            if (busy) busy_cnt++;
            if (done) seen = 1;
            else @(negedge clk);
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'(1));
        e = sb.pop_front();
        if (seen) begin
            chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
            chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
            chk({tag, "_dz"}, 64'(div_zero), 64'(e.dz));
            chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(33));
            chk({tag, "_busy_with_done"}, 64'(busy), 64'(0));
            @(negedge clk);
            chk({tag, "_done_width"}, 64'(done), 64'(0));
        end
    endtask

    initial begin
        int done_cnt;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
        op = 2'b00; rs_val = '0; rt_val = '0; wdata = '0;
        #12;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_dz", 64'(div_zero), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        run_op("divu_zero", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        run_op("divu_after", 2'b11, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);

        @(negedge clk);
        mthi_we = 1'b1; wdata = 32'h11;
        @(negedge clk);
        mthi_we = 1'b0; mtlo_we = 1'b1; wdata = 32'h22;
        @(negedge clk);
        mtlo_we = 1'b0;
        chk("mthi", 64'(hi), 64'(32'h11));
        chk("mtlo", 64'(lo), 64'(32'h22));

        start = 1'b1; op = 2'b01; rs_val = 32'd100; rt_val = 32'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; mtlo_we = 1'b1; wdata = 32'h99;
        @(negedge clk);
        start = 1'b0; mtlo_we = 1'b0;
        chk("busy_move_lo", 64'(lo), 64'(32'h22));
        repeat (6) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_hi", 64'(hi), 64'(32'h11));
        chk("abort_lo", 64'(lo), 64'(32'h22));
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        chk("abort_no_done", 64'(done_cnt), 64'(0));
        chk("abort_stays_idle", 64'(busy), 64'(0));

        mthi_we = 1'b1; wdata = 32'h55;
        run_op("start_vs_mthi", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

        @(negedge clk);
        start = 1'b1; op = 2'b01; rs_val = 32'd1000; rt_val = 32'd1000;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_hi", 64'(hi), 64'(0));
        chk("midrst_lo", 64'(lo), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_op("multu_post_rst", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
